// File: rtl/mcu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MCU controller: opcodes, state codes and
// the memory / register-file / ALU control values driven onto the datapath.
package mcu_ctrl_pkg;

    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_ADD  = 4'h1;
    localparam logic [3:0] OPC_SUB  = 4'h2;
    localparam logic [3:0] OPC_AND  = 4'h3;
    localparam logic [3:0] OPC_OR   = 4'h4;
    localparam logic [3:0] OPC_XOR  = 4'h5;
    localparam logic [3:0] OPC_ADDI = 4'h6;
    localparam logic [3:0] OPC_LD   = 4'h7;
    localparam logic [3:0] OPC_ST   = 4'h8;
    localparam logic [3:0] OPC_JMP  = 4'h9;
    localparam logic [3:0] OPC_BZ   = 4'hA;
    localparam logic [3:0] OPC_BC   = 4'hB;
    localparam logic [3:0] OPC_HLT  = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6,
        S_IRQ    = 3'd7
    } state_t;

    localparam logic [1:0] MEM_IDLE   = 2'b00;
    localparam logic [1:0] MEM_IFETCH = 2'b01;
    localparam logic [1:0] MEM_RD     = 2'b10;
    localparam logic [1:0] MEM_WR     = 2'b11;

    localparam logic [1:0] REG_NONE = 2'b00;
    localparam logic [1:0] REG_RD   = 2'b01;
    localparam logic [1:0] REG_WR   = 2'b10;

    localparam logic [3:0] ALU_PASS = 4'h0;
    localparam logic [3:0] ALU_ADD  = 4'h1;

endpackage

// File: rtl/mcu_ctrl_wait_timer.sv
// Counts consecutive cycles spent waiting on mem_rdy; expire flags the last
// permitted wait cycle so the controller can divert to FAULT. WAIT_MAX=0 never expires.
module mcu_ctrl_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (enable) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    generate
        if (WAIT_MAX > 0) begin : g_limit
            assign expire = (wait_cnt == CNT_W'(WAIT_MAX - 1));
        end else begin : g_no_limit
            assign expire = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/mcu_ctrl_mc.sv
// Multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB with memory wait timeout, HALT and FAULT.
// Define MCU_CTRL_IRQ_EN to add the irq/irq_ack ports and the one-cycle IRQ vector state.
module mcu_ctrl_mc
    import mcu_ctrl_pkg::*;
#(
    parameter int OP_W      = 4,
    parameter int FLAG_W    = 2,
    parameter int ALU_CTR_W = 4,
    parameter int WAIT_MAX  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OP_W-1:0]      OP,
    input  logic [1:0]           SM,
    input  logic [FLAG_W-1:0]    Flag,
    input  logic                 mem_rdy,
`ifdef MCU_CTRL_IRQ_EN
    input  logic                 irq,
    output logic                 irq_ack,
`endif
    output logic                 PC_E,
    output logic                 REG_E,
    output logic                 ALU_E,
    output logic                 MEM_E,
    output logic                 PC_Ctr,
    output logic [1:0]           Mem_Ctr,
    output logic [1:0]           Reg_Ctr,
    output logic [ALU_CTR_W-1:0] ALU_Ctr,
    output logic                 ALU_IN,
    output logic                 MemToReg,
    output logic                 Reg_Dst,
    output logic [2:0]           state_o,
    output logic                 halted,
    output logic                 fault
);

    state_t          state_reg, state_next;
    logic [OP_W-1:0] ir_op;
    logic [1:0]      ir_sm;
    logic [3:0]      op, op_in;
    logic            timer_en, timer_clr, timer_expire;

    // Opcodes wider than 4 bits with any upper bit set are illegal and decode as NOP.
    generate
        if (OP_W > 4) begin : g_wide_op
            assign op    = (|ir_op[OP_W-1:4]) ? OPC_NOP : ir_op[3:0];
            assign op_in = (|OP[OP_W-1:4])    ? OPC_NOP : OP[3:0];
        end else begin : g_narrow_op
            assign op    = 4'(ir_op);
            assign op_in = 4'(OP);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_FETCH;
            ir_op     <= '0;
            ir_sm     <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE) begin
                ir_op <= OP;
                ir_sm <= SM;
            end
        end
    end

    assign timer_clr = (state_next != state_reg) || mem_rdy;

    mcu_ctrl_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clr),
        .enable (timer_en),
        .expire (timer_expire)
    );

    always_comb begin
        state_next = state_reg;
        timer_en   = 1'b0;
        PC_E       = 1'b0;
        REG_E      = 1'b0;
        ALU_E      = 1'b0;
        MEM_E      = 1'b0;
        PC_Ctr     = 1'b0;
        Mem_Ctr    = MEM_IDLE;
        Reg_Ctr    = REG_NONE;
        ALU_Ctr    = '0;
        ALU_IN     = 1'b0;
        MemToReg   = 1'b0;
        Reg_Dst    = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
`ifdef MCU_CTRL_IRQ_EN
        irq_ack    = 1'b0;
`endif
        unique case (state_reg)
            S_FETCH: begin
                MEM_E   = 1'b1;
                Mem_Ctr = MEM_IFETCH;
                if (mem_rdy) begin
                    PC_E       = 1'b1;
                    state_next = S_DECODE;
                end else if (timer_expire) begin
                    state_next = S_FAULT;
                end else begin
                    timer_en = 1'b1;
                end
            end
            S_DECODE: begin
                REG_E      = 1'b1;
                Reg_Ctr    = REG_RD;
                state_next = (op_in == OPC_HLT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                ALU_E      = 1'b1;
                ALU_IN     = ir_sm[0] | (op == OPC_ADDI);
                state_next = S_FETCH;
                case (op)
                    OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR: begin
                        ALU_Ctr    = ALU_CTR_W'(op);
                        state_next = S_WB;
                    end
                    OPC_ADDI: begin
                        ALU_Ctr    = ALU_CTR_W'(ALU_ADD);
                        state_next = S_WB;
                    end
                    OPC_LD, OPC_ST: begin
                        ALU_Ctr    = ALU_CTR_W'(ALU_ADD);
                        state_next = S_MEM;
                    end
                    OPC_JMP: begin
                        PC_E   = 1'b1;
                        PC_Ctr = 1'b1;
                    end
                    OPC_BZ: begin
                        PC_E   = Flag[0];
                        PC_Ctr = Flag[0];
                    end
                    OPC_BC: begin
                        PC_E   = Flag[1];
                        PC_Ctr = Flag[1];
                    end
                    default: ALU_Ctr = ALU_CTR_W'(ALU_PASS);
                endcase
            end
            S_MEM: begin
                MEM_E   = 1'b1;
                Mem_Ctr = (op == OPC_ST) ? MEM_WR : MEM_RD;
                if (mem_rdy) begin
                    state_next = (op == OPC_ST) ? S_FETCH : S_WB;
                end else if (timer_expire) begin
                    state_next = S_FAULT;
                end else begin
                    timer_en = 1'b1;
                end
            end
            S_WB: begin
                REG_E      = 1'b1;
                Reg_Ctr    = REG_WR;
                Reg_Dst    = ir_sm[1];
                MemToReg   = (op == OPC_LD);
                state_next = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
`ifdef MCU_CTRL_IRQ_EN
            S_IRQ: begin
                PC_E       = 1'b1;
                PC_Ctr     = 1'b1;
                irq_ack    = 1'b1;
                state_next = S_FETCH;
            end
`endif
            default: state_next = S_FETCH;
        endcase
`ifdef MCU_CTRL_IRQ_EN
        // Interrupts are taken only at instruction boundaries, never from a FETCH wait.
        if (irq && state_next == S_FETCH && state_reg != S_FETCH && state_reg != S_IRQ) begin
            state_next = S_IRQ;
        end
`endif
        // Outputs are quiet for as long as reset is held.
        if (!rst) begin
            PC_E     = 1'b0;
            REG_E    = 1'b0;
            ALU_E    = 1'b0;
            MEM_E    = 1'b0;
            PC_Ctr   = 1'b0;
            Mem_Ctr  = MEM_IDLE;
            Reg_Ctr  = REG_NONE;
            ALU_Ctr  = '0;
            ALU_IN   = 1'b0;
            MemToReg = 1'b0;
            Reg_Dst  = 1'b0;
            halted   = 1'b0;
            fault    = 1'b0;
`ifdef MCU_CTRL_IRQ_EN
            irq_ack  = 1'b0;
`endif
        end
    end

    assign state_o = state_reg;

endmodule

// File: tb/tb_mcu_ctrl_mc.sv
// Directed bench for mcu_ctrl_mc; the IRQ scenario runs when MCU_CTRL_IRQ_EN is defined.
module tb_mcu_ctrl_mc;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic [3:0] OP      = 4'h0;
    logic [1:0] SM      = 2'b00;
    logic [1:0] Flag    = 2'b00;
    logic       mem_rdy = 1'b0;
`ifdef MCU_CTRL_IRQ_EN
    logic       irq     = 1'b0;
    logic       irq_ack;
`endif
    logic       PC_E, REG_E, ALU_E, MEM_E, PC_Ctr, ALU_IN, MemToReg, Reg_Dst;
    logic [1:0] Mem_Ctr, Reg_Ctr;
    logic [3:0] ALU_Ctr;
    logic [2:0] state_o;
    logic       halted, fault;
    logic [17:0] outs;
    logic [3:0]  enables;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mcu_ctrl_mc #(.OP_W(4), .FLAG_W(2), .ALU_CTR_W(4), .WAIT_MAX(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .OP       (OP),
        .SM       (SM),
        .Flag     (Flag),
        .mem_rdy  (mem_rdy),
`ifdef MCU_CTRL_IRQ_EN
        .irq      (irq),
        .irq_ack  (irq_ack),
`endif
        .PC_E     (PC_E),
        .REG_E    (REG_E),
        .ALU_E    (ALU_E),
        .MEM_E    (MEM_E),
        .PC_Ctr   (PC_Ctr),
        .Mem_Ctr  (Mem_Ctr),
        .Reg_Ctr  (Reg_Ctr),
        .ALU_Ctr  (ALU_Ctr),
        .ALU_IN   (ALU_IN),
        .MemToReg (MemToReg),
        .Reg_Dst  (Reg_Dst),
        .state_o  (state_o),
        .halted   (halted),
        .fault    (fault)
    );

    assign outs    = {PC_E, REG_E, ALU_E, MEM_E, PC_Ctr, Mem_Ctr, Reg_Ctr, ALU_Ctr,
                      ALU_IN, MemToReg, Reg_Dst, halted, fault};
    assign enables = {PC_E, REG_E, ALU_E, MEM_E};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs FETCH (mem_rdy high) and DECODE; returns at the start of the following state.
    task automatic fetch_decode(input logic [3:0] op, input logic [1:0] sm);
        OP      = op;
        SM      = sm;
        mem_rdy = 1'b1;
        #1;
        check("fetch_state", 32'(state_o), 0);
        check("fetch_outs", {28'd0, MEM_E, PC_E, Mem_Ctr}, {28'd0, 1'b1, 1'b1, 2'b01});
        cyc();
        #1;
        check("decode_state", 32'(state_o), 1);
        check("decode_reg", {30'd0, REG_E, Reg_Ctr}, {30'd0, 1'b1, 2'b01});
        cyc();
        OP = 4'h0;
        SM = 2'b00;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_state", 32'(state_o), 0);
        check("rst_outs", 32'(outs), 0);
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic exec_branch(input string tag, input logic [3:0] op, input logic [1:0] flg,
                               input logic taken);
        fetch_decode(op, 2'b00);
        Flag = flg;
        #1;
        check({tag, "_state"}, 32'(state_o), 2);
        check({tag, "_pc"}, {30'd0, PC_E, PC_Ctr}, {30'd0, taken, taken});
        cyc();
        Flag = 2'b00;
        $display("txn %s op=%h flag=%b", tag, op, flg);
    endtask

    initial begin
        #1;
        do_reset();

        // ADD: FETCH, DECODE, EXEC, WB
        fetch_decode(4'h1, 2'b00);
        #1;
        check("add_exec_state", 32'(state_o), 2);
        check("add_exec", {26'd0, ALU_E, ALU_Ctr, ALU_IN}, {26'd0, 1'b1, 4'h1, 1'b0});
        cyc();
        #1;
        check("add_wb_state", 32'(state_o), 4);
        check("add_wb", {27'd0, REG_E, Reg_Ctr, Reg_Dst, MemToReg}, {27'd0, 1'b1, 2'b10, 1'b0, 1'b0});
        cyc();
        $display("txn ADD sm=00");

        // SUB with immediate mode: ALU_Ctr follows the opcode, ALU_IN follows SM[0]
        fetch_decode(4'h2, 2'b01);
        #1;
        check("sub_exec", {27'd0, ALU_Ctr, ALU_IN}, {27'd0, 4'h2, 1'b1});
        cyc();
        cyc();
        $display("txn SUB sm=01");

        // ADDI: ALU add, immediate operand forced, destination select from SM[1]
        fetch_decode(4'h6, 2'b10);
        #1;
        check("addi_exec", {27'd0, ALU_Ctr, ALU_IN}, {27'd0, 4'h1, 1'b1});
        cyc();
        #1;
        check("addi_wb", {29'd0, state_o == 3'd4, Reg_Dst, MemToReg}, {29'd0, 1'b1, 1'b1, 1'b0});
        cyc();
        $display("txn ADDI sm=10");

        // LD with three wait cycles in MEM
        fetch_decode(4'h7, 2'b10);
        #1;
        check("ld_exec", {27'd0, ALU_Ctr, ALU_IN}, {27'd0, 4'h1, 1'b0});
        cyc();
        mem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ld_mem_wait", {27'd0, state_o, MEM_E, Mem_Ctr == 2'b10}, {27'd0, 3'd3, 1'b1, 1'b1});
            cyc();
        end
        mem_rdy = 1'b1;
        #1;
        check("ld_mem_last", {28'd0, state_o, Mem_Ctr == 2'b10}, {28'd0, 3'd3, 1'b1});
        cyc();
        #1;
        check("ld_wb", {26'd0, state_o, Reg_Ctr, MemToReg, Reg_Dst}, {26'd0, 3'd4, 2'b10, 1'b1, 1'b1});
        cyc();
        $display("txn LD sm=10 waits=3");

        // ST: EXEC, MEM write, straight back to FETCH
        fetch_decode(4'h8, 2'b00);
        cyc();
        #1;
        check("st_mem", {27'd0, state_o, Mem_Ctr}, {27'd0, 3'd3, 2'b11});
        cyc();
        #1;
        check("st_next", 32'(state_o), 0);
        $display("txn ST");

        exec_branch("bz_taken", 4'hA, 2'b01, 1'b1);
        exec_branch("bz_not",   4'hA, 2'b00, 1'b0);
        exec_branch("bc_taken", 4'hB, 2'b10, 1'b1);
        exec_branch("bc_not",   4'hB, 2'b01, 1'b0);
        exec_branch("jmp",      4'h9, 2'b00, 1'b1);

        // Illegal opcode executes as NOP
        fetch_decode(4'hC, 2'b00);
        #1;
        check("ill_exec", {27'd0, ALU_Ctr, PC_E}, {27'd0, 4'h0, 1'b0});
        cyc();
        #1;
        check("ill_next", 32'(state_o), 0);
        $display("txn ILLEGAL op=C");

        // HLT: parks in HALT with all enables low
        fetch_decode(4'hF, 2'b00);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("halt_state", {27'd0, state_o, halted, enables == 4'd0}, {27'd0, 3'd5, 1'b1, 1'b1});
            cyc();
        end
        $display("txn HLT");
        do_reset();

        // Ready on the last permitted wait cycle wins over the timeout
        mem_rdy = 1'b0;
        for (int i = 0; i < 14; i++) begin
            #1;
            check("edge_wait", 32'(state_o), 0);
            cyc();
        end
        mem_rdy = 1'b1;
        OP = 4'h1;
        #1;
        check("edge_ready", 32'(state_o), 0);
        cyc();
        #1;
        check("edge_decode", 32'(state_o), 1);
        cyc();
        cyc();
        cyc();
        $display("txn FETCH ready at wait limit");

        // FETCH timeout: 15 waiting cycles then FAULT, held until reset
        mem_rdy = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            check("to_wait", 32'(state_o), 0);
            cyc();
        end
        #1;
        check("to_fault", {27'd0, state_o, fault, enables == 4'd0}, {27'd0, 3'd6, 1'b1, 1'b1});
        mem_rdy = 1'b1;
        cyc();
        cyc();
        cyc();
        #1;
        check("to_hold", {30'd0, state_o == 3'd6, fault}, {30'd0, 1'b1, 1'b1});
        $display("txn FETCH timeout");
        do_reset();

        // Reset asserted mid-MEM abandons the access at once
        fetch_decode(4'h7, 2'b00);
        cyc();
        mem_rdy = 1'b0;
        #1;
        check("mid_mem", 32'(state_o), 3);
        rst = 1'b0;
        #1;
        check("mid_rst_state", 32'(state_o), 0);
        check("mid_rst_outs", 32'(outs), 0);
        cyc();
        rst = 1'b1;
        #1;
        check("post_rst_fetch", {30'd0, MEM_E, state_o == 3'd0}, {30'd0, 1'b1, 1'b1});
        $display("txn reset mid-MEM");

`ifdef MCU_CTRL_IRQ_EN
        // IRQ raised during WB diverts the return to FETCH through IRQ
        fetch_decode(4'h1, 2'b00);
        cyc();
        irq = 1'b1;
        #1;
        check("irq_wb", 32'(state_o), 4);
        cyc();
        irq = 1'b0;
        #1;
        check("irq_state", {27'd0, state_o, irq_ack, PC_E, PC_Ctr}, {27'd0, 3'd7, 1'b1, 1'b1, 1'b1});
        cyc();
        #1;
        check("irq_back", 32'(state_o), 0);
        $display("txn IRQ after ADD");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
